// File: rtl/down_counter_timer_if.sv
// Load handshake bundle for down_counter_timer.
// The prescale field exists only when DOWNCOUNT_PRESCALE_EN is defined.
interface down_counter_timer_if #(
   parameter int W = 48
`ifdef DOWNCOUNT_PRESCALE_EN
   ,parameter int PRE_W = 8
`endif
);
   logic           load_valid;
   logic           load_ready;
   logic [W-1:0]   load_value;
   logic           auto_reload;
`ifdef DOWNCOUNT_PRESCALE_EN
   logic [PRE_W-1:0] prescale;
`endif

   modport master (
      output load_valid,
      output load_value,
      output auto_reload,
`ifdef DOWNCOUNT_PRESCALE_EN
      output prescale,
`endif
      input  load_ready
   );

   modport slave (
      input  load_valid,
      input  load_value,
      input  auto_reload,
`ifdef DOWNCOUNT_PRESCALE_EN
      input  prescale,
`endif
      output load_ready
   );
endinterface

// File: rtl/down_counter_timer.sv
// Loadable W-bit down-counting timer, one-shot or auto-reload, with a
// registered one-cycle expire pulse at the terminal count.
// Optional feature macro: DOWNCOUNT_PRESCALE_EN (adds a per-step prescaler).
module down_counter_timer #(
   parameter int W = 48
`ifdef DOWNCOUNT_PRESCALE_EN
   ,parameter int PRE_W = 8
`endif
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                en,
   input  logic                abort,
   down_counter_timer_if.slave ld,
   output logic [W-1:0]        count,
   output logic                busy,
   output logic                expire
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t       state, state_nx;
   logic [W-1:0] count_nx;
   logic [W-1:0] reload_reg, reload_nx;
   logic         mode_reg, mode_nx;
   logic         expire_nx;
   logic         step;
`ifdef DOWNCOUNT_PRESCALE_EN
   logic [PRE_W-1:0] pre_cnt, pre_cnt_nx;
   logic [PRE_W-1:0] pre_reg, pre_reg_nx;
`endif

   assign busy          = (state == RUN);
   assign ld.load_ready = (state == IDLE);

   // A count step happens on every enabled cycle, or only when the prescaler has run out.
`ifdef DOWNCOUNT_PRESCALE_EN
   assign step = (pre_cnt == '0);
`else
   assign step = 1'b1;
`endif

   // Register all timer state; reset clears everything and suppresses expire.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         count      <= '0;
         reload_reg <= '0;
         mode_reg   <= 1'b0;
         expire     <= 1'b0;
`ifdef DOWNCOUNT_PRESCALE_EN
         pre_cnt    <= '0;
         pre_reg    <= '0;
`endif
      end else begin
         state      <= state_nx;
         count      <= count_nx;
         reload_reg <= reload_nx;
         mode_reg   <= mode_nx;
         expire     <= expire_nx;
`ifdef DOWNCOUNT_PRESCALE_EN
         pre_cnt    <= pre_cnt_nx;
         pre_reg    <= pre_reg_nx;
`endif
      end
   end

   // Next-state logic: load acceptance in IDLE; abort, decrement and terminal handling in RUN.
   always_comb begin
      state_nx   = state;
      count_nx   = count;
      reload_nx  = reload_reg;
      mode_nx    = mode_reg;
      expire_nx  = 1'b0;
`ifdef DOWNCOUNT_PRESCALE_EN
      pre_cnt_nx = pre_cnt;
      pre_reg_nx = pre_reg;
`endif
      unique case (state)
         IDLE: begin
            if (ld.load_valid) begin
               if (ld.load_value == '0) begin
                  // Zero load expires immediately and never enters RUN.
                  expire_nx = 1'b1;
                  count_nx  = '0;
               end else begin
                  count_nx  = ld.load_value;
                  reload_nx = ld.load_value;
                  mode_nx   = ld.auto_reload;
                  state_nx  = RUN;
               end
`ifdef DOWNCOUNT_PRESCALE_EN
               pre_reg_nx = ld.prescale;
               pre_cnt_nx = ld.prescale;
`endif
            end
         end
         RUN: begin
            if (abort) begin
               // Abort wins over decrement and terminal, so no expire here.
               count_nx = '0;
               state_nx = IDLE;
`ifdef DOWNCOUNT_PRESCALE_EN
               pre_cnt_nx = '0;
`endif
            end else if (en) begin
               if (step) begin
`ifdef DOWNCOUNT_PRESCALE_EN
                  pre_cnt_nx = pre_reg;
`endif
                  if (count == W'(1)) begin
                     expire_nx = 1'b1;
                     if (mode_reg) begin
                        count_nx = reload_reg;
                     end else begin
                        count_nx = '0;
                        state_nx = IDLE;
                     end
                  end else if (count != '0) begin
                     count_nx = count - W'(1);
                  end
               end else begin
`ifdef DOWNCOUNT_PRESCALE_EN
                  pre_cnt_nx = pre_cnt - PRE_W'(1);
`endif
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule
